// File: rtl/reset_sequencer.sv
// Parametrised cold/warm reset sequencer: synchronises and debounces PLL lock and keys,
// then releases reset domains in ascending order. Optional watchdog: define RSTSEQ_WDT_EN.
module reset_sequencer #(
    parameter int NUM_KEYS        = 2,
    parameter int NUM_DOMAINS     = 3,
    parameter int WARM_FIRST      = 1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STRETCH_CYCLES  = 255,
    parameter int WDT_CYCLES      = 1048576
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pll_locked_i,
    input  logic [NUM_KEYS-1:0]    key_n_i,
    input  logic                   wdt_kick_i,
    output logic                   por_o,
    output logic [NUM_DOMAINS-1:0] rst_o,
    output logic                   busy_o,
    output logic [1:0]             cause_o,
    output logic                   wdt_flag_o
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W  = $clog2(STRETCH_CYCLES + 1);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [DB_W-1:0]        DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0]        ST_LAST   = ST_W'(STRETCH_CYCLES - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0]       IDX_WARM  = IDX_W'(WARM_FIRST);
    localparam logic [NUM_DOMAINS-1:0] ALL_ONES  = {NUM_DOMAINS{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] ZERO_D    = {NUM_DOMAINS{1'b0}};
    localparam logic [NUM_DOMAINS-1:0] WARM_MASK = ALL_ONES << WARM_FIRST;

    localparam logic [1:0] CAUSE_PWR  = 2'b00;
    localparam logic [1:0] CAUSE_COLD = 2'b01;
    localparam logic [1:0] CAUSE_WARM = 2'b10;

    if (WARM_FIRST < 0 || WARM_FIRST >= NUM_DOMAINS) begin : g_bad_warm_first
        $error("reset_sequencer: WARM_FIRST must lie in [0, NUM_DOMAINS)");
    end

    typedef enum logic [1:0] {
        COLD_HOLD = 2'd0,
        WARM_HOLD = 2'd1,
        STRETCH   = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic                   lock_meta_r, lock_sync_r;
    logic [NUM_KEYS-1:0]    key_meta_r, key_sync_r, key_db_r;
    logic [DB_W-1:0]        db_cnt_r [NUM_KEYS];

    state_t                 state_r, state_s;
    logic                   seq_cold_r, seq_cold_s;
    logic [IDX_W-1:0]       cur_r, cur_s;
    logic [ST_W-1:0]        st_cnt_r, st_cnt_s;
    logic [NUM_DOMAINS-1:0] rst_r, rst_s;
    logic                   por_r, por_s;
    logic                   busy_r, busy_s;
    logic [1:0]             cause_r, cause_s;
    logic                   flag_r, flag_s;
    logic                   warm_any_s;

`ifdef RSTSEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST  = WDT_W'(WDT_CYCLES - 1);
    localparam logic [1:0]       CAUSE_WDT = 2'b11;
    logic [WDT_W-1:0] wdt_cnt_r, wdt_cnt_s;
`else
    logic [1:0] wdt_unused;
    assign wdt_unused = {wdt_kick_i, (WDT_CYCLES > 0)};
`endif

    // Two-flop synchronisers for the asynchronous lock and key inputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
            key_meta_r  <= {NUM_KEYS{1'b1}};
            key_sync_r  <= {NUM_KEYS{1'b1}};
        end else begin
            lock_meta_r <= pll_locked_i;
            lock_sync_r <= lock_meta_r;
            key_meta_r  <= key_n_i;
            key_sync_r  <= key_meta_r;
        end
    end

    // Per-key debounce: level flips only after DEBOUNCE_CYCLES consecutive mismatching cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_db_r <= {NUM_KEYS{1'b1}};
            for (int k = 0; k < NUM_KEYS; k++) db_cnt_r[k] <= {DB_W{1'b0}};
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (key_sync_r[k] == key_db_r[k]) begin
                    db_cnt_r[k] <= {DB_W{1'b0}};
                end else if (db_cnt_r[k] == DB_LAST) begin
                    db_cnt_r[k] <= {DB_W{1'b0}};
                    key_db_r[k] <= key_sync_r[k];
                end else begin
                    db_cnt_r[k] <= db_cnt_r[k] + DB_W'(1);
                end
            end
        end
    end

    // Any debounced warm key (index 1 upward) currently pressed
    always_comb begin
        warm_any_s = 1'b0;
        for (int k = 1; k < NUM_KEYS; k++) warm_any_s = warm_any_s | ~key_db_r[k];
    end

    // Next-state and next-output logic; cold requests override everything else
    always_comb begin
        state_s    = state_r;
        seq_cold_s = seq_cold_r;
        cur_s      = cur_r;
        st_cnt_s   = {ST_W{1'b0}};
        rst_s      = rst_r;
        por_s      = por_r;
        cause_s    = cause_r;
        flag_s     = flag_r;
`ifdef RSTSEQ_WDT_EN
        wdt_cnt_s  = {WDT_W{1'b0}};
`endif
        if (!lock_sync_r || !key_db_r[0]) begin
            state_s    = COLD_HOLD;
            seq_cold_s = 1'b1;
            cur_s      = {IDX_W{1'b0}};
            rst_s      = ALL_ONES;
            por_s      = 1'b1;
            flag_s     = 1'b0;
            cause_s    = lock_sync_r ? CAUSE_COLD : CAUSE_PWR;
        end else begin
            case (state_r)
                COLD_HOLD: begin
                    state_s = STRETCH;
                    cur_s   = {IDX_W{1'b0}};
                end
                WARM_HOLD: begin
                    if (warm_any_s) begin
                        state_s = WARM_HOLD;
                    end else begin
                        state_s = STRETCH;
                        cur_s   = IDX_WARM;
                    end
                end
                STRETCH: begin
                    // Warm keys are ignored until a cold sequence reaches RUN
                    if (warm_any_s && !seq_cold_r) begin
                        state_s = WARM_HOLD;
                        rst_s   = rst_r | WARM_MASK;
                        por_s   = 1'b0;
                        cause_s = CAUSE_WARM;
                    end else if (st_cnt_r == ST_LAST) begin
                        rst_s[cur_r] = 1'b0;
                        if (cur_r == {IDX_W{1'b0}}) begin
                            por_s = 1'b0;
                        end else begin
                            por_s = por_r;
                        end
                        if (cur_r == IDX_LAST) begin
                            state_s    = RUN;
                            seq_cold_s = 1'b0;
                        end else begin
                            cur_s = cur_r + IDX_W'(1);
                        end
                    end else begin
                        st_cnt_s = st_cnt_r + ST_W'(1);
                    end
                end
                RUN: begin
                    if (warm_any_s) begin
                        state_s = WARM_HOLD;
                        rst_s   = rst_r | WARM_MASK;
                        por_s   = 1'b0;
                        cause_s = CAUSE_WARM;
                    end
`ifdef RSTSEQ_WDT_EN
                    else if (wdt_kick_i) begin
                        rst_s = ZERO_D;
                        por_s = 1'b0;
                    end else if (wdt_cnt_r == WDT_LAST) begin
                        state_s = WARM_HOLD;
                        rst_s   = rst_r | WARM_MASK;
                        por_s   = 1'b0;
                        cause_s = CAUSE_WDT;
                        flag_s  = 1'b1;
                    end else begin
                        wdt_cnt_s = wdt_cnt_r + WDT_W'(1);
                        rst_s     = ZERO_D;
                        por_s     = 1'b0;
                    end
`else
                    else begin
                        rst_s = ZERO_D;
                        por_s = 1'b0;
                    end
`endif
                end
                default: begin
                    state_s    = COLD_HOLD;
                    seq_cold_s = 1'b1;
                    rst_s      = ALL_ONES;
                    por_s      = 1'b1;
                end
            endcase
        end
        busy_s = |rst_s;
    end

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= COLD_HOLD;
            seq_cold_r <= 1'b1;
            cur_r      <= {IDX_W{1'b0}};
            st_cnt_r   <= {ST_W{1'b0}};
            rst_r      <= ALL_ONES;
            por_r      <= 1'b1;
            busy_r     <= 1'b1;
            cause_r    <= CAUSE_PWR;
            flag_r     <= 1'b0;
`ifdef RSTSEQ_WDT_EN
            wdt_cnt_r  <= {WDT_W{1'b0}};
`endif
        end else begin
            state_r    <= state_s;
            seq_cold_r <= seq_cold_s;
            cur_r      <= cur_s;
            st_cnt_r   <= st_cnt_s;
            rst_r      <= rst_s;
            por_r      <= por_s;
            busy_r     <= busy_s;
            cause_r    <= cause_s;
            flag_r     <= flag_s;
`ifdef RSTSEQ_WDT_EN
            wdt_cnt_r  <= wdt_cnt_s;
`endif
        end
    end

    assign por_o      = por_r;
    assign rst_o      = rst_r;
    assign busy_o     = busy_r;
    assign cause_o    = cause_r;
    assign wdt_flag_o = flag_r;

endmodule
